// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the PWM/output-enable configuration bank: register map and FSM encoding.
package pwm_cfg_pkg;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY  = 4;
  localparam int NUM_REGS       = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_cfg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. last_grant resets to 1 so port 0 wins the first contested grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (adv_i && (|req_i)) last_d = gnt_o[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// PWM/output-enable config bank with a shared, round-robin arbitrated write path (SPI port 0,
// sequencer port 1). Define PWM_CFG_SHADOW_EN to stage writes in a shadow bank applied on commit.
import pwm_cfg_pkg::*;

module pwm_cfg_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = pwm_cfg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PWM_CFG_SHADOW_EN
  input  logic              commit,
`endif
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_err,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              gid_q, gid_d;
  logic [1:0]        gnt;
  logic              in_write, addr_ok, wr_en;

  logic [DATA_W-1:0] out_q [NUM_REGS];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1_valid, req0_valid}),
    .adv_i (state_q == S_IDLE),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    unique case (state_q)
      S_IDLE: begin
        // Capture at grant so requester changes during WRITE cannot corrupt the write.
        if (req0_valid || req1_valid) begin
          state_d = S_WRITE;
          gid_d   = gnt[1];
          addr_d  = gnt[1] ? req1_addr : req0_addr;
          data_d  = gnt[1] ? req1_data : req0_data;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign in_write   = (state_q == S_WRITE);
  assign addr_ok    = (addr_q < ADDR_W'(NUM_REGS));
  assign wr_en      = in_write && addr_ok;
  assign req0_ready = in_write && !gid_q;
  assign req1_ready = in_write &&  gid_q;
  assign wr_err     = in_write && !addr_ok;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic hit;
    assign hit = wr_en && (addr_q == ADDR_W'(i));
`ifdef PWM_CFG_SHADOW_EN
    logic [DATA_W-1:0] shadow_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        out_q[i] <= '0;
      end else begin
        if (hit)    shadow_q <= data_q;
        // Non-blocking read: a commit coinciding with a write applies the pre-write value.
        if (commit) out_q[i] <= shadow_q;
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   out_q[i] <= '0;
      else if (hit) out_q[i] <= data_q;
    end
`endif
  end

  assign en_reg_out_7_0  = out_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = out_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = out_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = out_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = out_q[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed self-checking bench for pwm_cfg_arbiter; also covers PWM_CFG_SHADOW_EN builds.
module tb_pwm_cfg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       commit = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, wr_err;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_cfg_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef PWM_CFG_SHADOW_EN
    .commit          (commit),
`endif
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .wr_err          (wr_err),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    commit     = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Makes staged writes visible in shadow builds; no-op otherwise.
  task automatic sync_outputs();
`ifdef PWM_CFG_SHADOW_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
`endif
  endtask

  // Single port-0 write from IDLE, completed and released.
  task automatic p0_write(input logic [6:0] a, input logic [7:0] d);
    req0_valid = 1'b1; req0_addr = a; req0_data = d;
    tick();
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({req0_ready, req1_ready, wr_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_hs: got %b want 000", {req0_ready, req1_ready, wr_err});
    end
    n_checks++;
    if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h want 0", {out_lo, out_hi, pwm_lo, pwm_hi, duty});
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    req0_valid = 1'b1; req0_addr = 7'd4; req0_data = 8'h80;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready, wr_err} !== 3'b100) begin
      n_fail++; $display("FAIL single_ready_n1: got %b want 100", {req0_ready, req1_ready, wr_err});
    end
    n_checks++;
    if (duty !== 8'h00) begin
      n_fail++; $display("FAIL single_duty_n1: got %h want 00", duty);
    end
    req0_valid = 1'b0;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL single_ready_n2: got %b want 00", {req0_ready, req1_ready});
    end
    sync_outputs();
    n_checks++;
    if (duty !== 8'h80) begin
      n_fail++; $display("FAIL single_duty_n2: got %h want 80", duty);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_addr = 7'd0; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_addr = 7'd1; req1_data = 8'h55;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL cont_n1: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL cont_n2: got %b want 00", {req0_ready, req1_ready});
    end
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL cont_n3: got %b want 01", {req0_ready, req1_ready});
    end
    req1_valid = 1'b0;
    tick();
    sync_outputs();
    n_checks++;
    if ({out_lo, out_hi} !== 16'hAA55) begin
      n_fail++; $display("FAIL cont_regs: got %h want aa55", {out_lo, out_hi});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_addr = 7'd2; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'd3; req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL b2b_grant%0d: got %b", k, {req0_ready, req1_ready});
      end
      tick();
    end
    req0_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fail++; $display("FAIL p1_alone%0d: got %b want 01", j, {req0_ready, req1_ready});
      end
      if (j == 1) req1_valid = 1'b0;
      tick();
    end
    sync_outputs();
    n_checks++;
    if ({pwm_lo, pwm_hi} !== 16'h1122) begin
      n_fail++; $display("FAIL b2b_regs: got %h want 1122", {pwm_lo, pwm_hi});
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    p0_write(7'd4, 8'h80);
    req1_valid = 1'b1; req1_addr = 7'h05; req1_data = 8'hFF;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready, wr_err} !== 3'b011) begin
      n_fail++; $display("FAIL bad5_n1: got %b want 011", {req0_ready, req1_ready, wr_err});
    end
    req1_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++; $display("FAIL bad5_err_n2: got %b want 0", wr_err);
    end
    // 0x44 aliases addr 4 if the compare were truncated.
    req0_valid = 1'b1; req0_addr = 7'h44; req0_data = 8'h01;
    tick();
    n_checks++;
    if ({req0_ready, wr_err} !== 2'b11) begin
      n_fail++; $display("FAIL bad44_n1: got %b want 11", {req0_ready, wr_err});
    end
    req0_valid = 1'b0;
    tick();
    sync_outputs();
    n_checks++;
    if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h00_00_00_00_80) begin
      n_fail++; $display("FAIL bad_regs: got %h want 0000000080", {out_lo, out_hi, pwm_lo, pwm_hi, duty});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    p0_write(7'd2, 8'h33);
    sync_outputs();
    n_checks++;
    if (pwm_lo !== 8'h33) begin
      n_fail++; $display("FAIL rmw_preload: got %h want 33", pwm_lo);
    end
    req0_valid = 1'b1; req0_addr = 7'd2; req0_data = 8'h0F;
    tick();
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmw_inwrite: got %b want 1", req0_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, pwm_lo} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rmw_abort: got %b/%h want 0/00", req0_ready, pwm_lo);
    end
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({req0_ready, pwm_lo} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rmw_after: got %b/%h want 0/00", req0_ready, pwm_lo);
    end
    // IDLE and last_grant=1 after reset: contested request goes to port 0 next cycle.
    req0_valid = 1'b1; req0_addr = 7'd0; req0_data = 8'h07;
    req1_valid = 1'b1; req1_addr = 7'd1; req1_data = 8'h08;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rmw_regrant: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

`ifdef PWM_CFG_SHADOW_EN
  task automatic test_shadow();
    do_reset();
    p0_write(7'd3, 8'h3C);
    n_checks++;
    if (pwm_hi !== 8'h00) begin
      n_fail++; $display("FAIL shd_staged: got %h want 00", pwm_hi);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_checks++;
    if (pwm_hi !== 8'h3C) begin
      n_fail++; $display("FAIL shd_commit: got %h want 3c", pwm_hi);
    end
    req0_valid = 1'b1; req0_addr = 7'd3; req0_data = 8'h5A;
    tick();
    req0_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_checks++;
    if (pwm_hi !== 8'h3C) begin
      n_fail++; $display("FAIL shd_commit_with_write: got %h want 3c", pwm_hi);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_checks++;
    if (pwm_hi !== 8'h5A) begin
      n_fail++; $display("FAIL shd_next_commit: got %h want 5a", pwm_hi);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_bad_addr();
    test_reset_mid_write();
`ifdef PWM_CFG_SHADOW_EN
    test_shadow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
